// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl
//
// Command-driven blink sequencer for a single board LED. A command of
// (on time, off time, repeat count) is taken over a valid/ready handshake.
// The LED then runs through the requested on/off sequence, timed in ticks
// derived from the system clock, and a one-cycle done pulse marks normal
// completion.
//
// Parameters:
//   CLOCK_FREQ  system clock frequency in Hz
//   TICK_HZ     tick rate; DIV = CLOCK_FREQ / TICK_HZ clocks per tick (>= 2)
//   PERIOD_W    width of the on/off durations, in ticks
//   COUNT_W     width of the repeat count
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  controller idle and able to accept a command
//   cmd_on     LED-on duration in ticks (0 = complete immediately)
//   cmd_off    LED-off duration in ticks (0 = LED stays lit between blinks)
//   cmd_count  number of on-phases (0 = run until abort)
//   abort      stop an active sequence without signalling done
//   led        registered LED drive
//   busy       registered, high while a sequence is active
//   done       registered one-cycle pulse on normal completion
module led_blink_ctrl #(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int PERIOD_W   = 16,
    parameter int COUNT_W    = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PERIOD_W-1:0] cmd_on,
    input  logic [PERIOD_W-1:0] cmd_off,
    input  logic [COUNT_W-1:0]  cmd_count,
    input  logic                abort,
    output logic                led,
    output logic                busy,
    output logic                done
);

    localparam int DIV   = CLOCK_FREQ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV);

    localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE    = DIV_W'(1);
    localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);
    localparam logic [COUNT_W-1:0]  COUNT_ONE  = COUNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIV_W-1:0]    div_cnt;
    logic [PERIOD_W-1:0] phase_cnt;
    logic [COUNT_W-1:0]  blink_cnt;

    logic [PERIOD_W-1:0] on_lat;
    logic [PERIOD_W-1:0] off_lat;
    logic [COUNT_W-1:0]  cnt_lat;

    logic accept;
    logic tick;
    logic on_end;
    logic off_end;
    logic last_blink;

    logic done_next;
    logic phase_clr;
    logic phase_inc;
    logic blink_inc;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (div_cnt == DIV_LAST);

    // Phase ends are only evaluated on a tick. The OFF state is never
    // entered with a zero off time, and ON never with a zero on time, so
    // the subtraction cannot wrap while it matters.
    assign on_end  = (phase_cnt == on_lat - PERIOD_ONE);
    assign off_end = (phase_cnt == off_lat - PERIOD_ONE);

    // A zero count means "forever": the final-blink condition never fires.
    assign last_blink = (cnt_lat != '0) && (blink_cnt == cnt_lat - COUNT_ONE);

    // Next-state logic. Abort has priority over the tick in ON and OFF.
    // A zero-length command completes straight from IDLE with a done pulse.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        phase_clr  = 1'b0;
        phase_inc  = 1'b0;
        blink_inc  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_on != '0) begin
                        state_next = S_ON;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            S_ON: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (tick) begin
                    if (on_end) begin
                        phase_clr = 1'b1;
                        if (cnt_lat != '0) begin
                            blink_inc = 1'b1;
                        end
                        if (last_blink) begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end else if (off_lat == '0) begin
                            state_next = S_ON;
                        end else begin
                            state_next = S_OFF;
                        end
                    end else begin
                        phase_inc = 1'b1;
                    end
                end
            end
            S_OFF: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (tick) begin
                    if (off_end) begin
                        phase_clr  = 1'b1;
                        state_next = S_ON;
                    end else begin
                        phase_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register and registered outputs. led and busy are computed
    // from the next state so they change in the same cycle as the state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
            led   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            led   <= (state_next == S_ON);
            busy  <= (state_next != S_IDLE);
            done  <= done_next;
        end
    end

    // Tick divider: free running, but restarted on accept so the first
    // phase of a sequence is exactly on * DIV cycles long.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (accept || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Phase and blink counters plus the latched command fields.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_cnt <= '0;
            blink_cnt <= '0;
            on_lat    <= '0;
            off_lat   <= '0;
            cnt_lat   <= '0;
        end else begin
            if (accept || phase_clr || state_next == S_IDLE) begin
                phase_cnt <= '0;
            end else if (phase_inc) begin
                phase_cnt <= phase_cnt + PERIOD_ONE;
            end

            if (accept) begin
                blink_cnt <= '0;
            end else if (blink_inc) begin
                blink_cnt <= blink_cnt + COUNT_ONE;
            end

            if (accept) begin
                on_lat  <= cmd_on;
                off_lat <= cmd_off;
                cnt_lat <= cmd_count;
            end
        end
    end

endmodule

// File: doc/led_blink_ctrl.md
# led_blink_ctrl

Command-driven blink sequencer for a single board LED. It accepts a blink command (on time, off time, repeat count) over a valid/ready interface and derives a millisecond-class tick from the system clock. It then drives the LED through the requested on/off sequence and signals completion. Higher-level logic (CPU status, debug) uses it instead of a free-running blinker.

## Interface

Parameters:
- CLOCK_FREQ, 12_000_000: system clock frequency in Hz.
- TICK_HZ, 1000: phase time unit rate; DIV = CLOCK_FREQ / TICK_HZ (integer truncation), must be ≥ 2.
- PERIOD_W, 16: width of on/off durations, in ticks.
- COUNT_W, 8: width of repeat count.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept; equals (state == IDLE).
- cmd_on  in  PERIOD_W  LED-on duration in ticks.
- cmd_off  in  PERIOD_W  LED-off duration in ticks.
- cmd_count  in  COUNT_W  number of on-phases; 0 = run until abort.
- abort  in  1  stop an active sequence.
- led  out  1  LED drive, registered.
- busy  out  1  sequence active (state != IDLE), registered.
- done  out  1  one-cycle pulse on normal completion.

## Operation

- Accept occurs when cmd_valid && cmd_ready at a rising edge. cmd_on, cmd_off and cmd_count are latched. The divider and phase counter clear on accept.
- Divider: counts 0..DIV-1 and wraps. tick = 1 for one cycle when the divider equals DIV-1. The divider runs freely in all states.
- FSM states are IDLE, ON and OFF.
  - IDLE: led = 0, busy = 0. On accept with cmd_on ≠ 0, go to ON. On accept with cmd_on = 0, stay in IDLE and pulse done the next cycle.
  - ON: led = 1. On each tick, the phase counter increments. The phase ends on the tick where phase counter == on-1.
    - At the end of the phase, the blink counter increments.
    - If count ≠ 0 and the blink count reaches count: go to IDLE and pulse done.
    - Else if off = 0: restart ON with the phase counter cleared, so led stays 1.
    - Else: go to OFF.
  - OFF: led = 0. The phase ends on the tick where phase counter == off-1, then go to ON.
- Count = 0: the blink counter does not advance and there is no overflow. The sequence ends only by abort or reset.
- abort in ON or OFF: next cycle is IDLE with led = 0, busy = 0, and no done. abort in IDLE is ignored.
- abort together with cmd_valid in IDLE: the command is accepted and abort is ignored.
- Reset (reset_n = 0 at an edge), including mid-sequence: state = IDLE, led = 0, busy = 0, done = 0. Divider, phase and blink counters = 0. cmd_valid is ignored while reset_n = 0.

## Timing

- Accept at the end of cycle 0: state, led and busy take their new values in cycle 1.
- ON phase lasts exactly on × DIV cycles. OFF phase lasts exactly off × DIV cycles.
- For count N: total active time = N·on·DIV + (N-1)·off·DIV cycles. done is high in the first cycle after the last ON cycle.
  - In that same cycle led = 0, busy = 0 and cmd_ready = 1.
  - A new command can be accepted in the done cycle, so back-to-back sequences have a gap of one led-low cycle.
- cmd_ready is 1 in the first cycle after reset release.
- done is never high for two consecutive cycles.

## Test plan

(Parameters for the bench: CLOCK_FREQ = 100, TICK_HZ = 10, so DIV = 10.)

- Reset: hold reset_n low 3 cycles with cmd_valid = 1 and cmd_on = 5 → led = 0, busy = 0, done = 0, no accept. After release, cmd_ready = 1.
- Counted sequence: accept on = 2, off = 3, count = 2 → led = 1 in cycles 1–20, 0 in 21–50, 1 in 51–70. done = 1 only in cycle 71. busy = 1 in 1–70, cmd_ready = 0 in 1–70.
- Zero cases:
  - on = 1, off = 0, count = 3 → led continuously 1 in cycles 1–30, done in cycle 31.
  - on = 0, count = 5 → done in cycle 1 only; led and busy stay 0.
- Continuous and abort: on = 1, off = 1, count = 0 → led toggles every 10 cycles through at least 300 cycles. Raise abort in cycle 137 → led = 0 and busy = 0 from cycle 138, done never asserted.
- Back-to-back: hold cmd_valid = 1 with a second command (on = 1, off = 1, count = 1) during the first command (on = 1, off = 1, count = 1) → second command accepted in the done cycle (cycle 11). led = 0 in cycle 11 and = 1 in cycles 12–21.
- Reset mid-ON: reset_n = 0 in cycle 5 of an on = 4 phase → led = 0 and busy = 0 in cycle 6. No done. cmd_ready = 1 once reset_n returns high.
